// File: rtl/pipo_rr_arbiter.sv
// pipo_rr_arbiter
//
// Round-robin write arbiter for a shared WIDTH-bit PIPO holding register.
// Four requesters each hold a level request and a data word. One requester
// is granted at a time, and its word is loaded into the shared register.
// A one-cycle acknowledge pulse confirms the load. The rotation pointer moves
// to the slot after the last winner, so a set of requesters that keeps
// requesting is served in strict rotation.
//
// Optional feature (compile-time macro PIPO_ARB_STATS_EN):
//   When defined, adds an 8-bit wr_count output. It counts completed loads
//   and wraps from 255 to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   req[3:0]  in   level request, bit i = requester i
//   d0..d3    in   WIDTH-bit write data of requesters 0..3
//   ack[3:0]  out  one-hot, one-cycle acknowledge of a completed load
//   q         out  shared register contents
//   q_valid   out  one-cycle pulse, concurrent with ack
//   owner     out  index of the requester that last wrote q
//   busy      out  high while in LOAD or ACK
//   wr_count  out  (PIPO_ARB_STATS_EN only) completed-load counter
//
// States:
//   state  | meaning
//   IDLE   | waiting for a request; arbitration happens here
//   LOAD   | winner latched; writes q on exit unless its request dropped
//   ACK    | ack/q_valid high for this single cycle, then back to IDLE

module pipo_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [1:0]       owner,
    output logic             busy
`ifdef PIPO_ARB_STATS_EN
    ,
    output logic [7:0]       wr_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       ack_q, ack_d;
    logic             q_valid_q, q_valid_d;

    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic             found;
    logic [WIDTH-1:0] d_sel;
    logic             load_done;

    // First set request bit, scanning upward from ptr with 2-bit wrap.
    always_comb begin
        win_idx = ptr_q;
        cand    = ptr_q;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        case (gnt_q)
            2'd0:    d_sel = d0;
            2'd1:    d_sel = d1;
            2'd2:    d_sel = d2;
            default: d_sel = d3;
        endcase
    end

    // A load completes only if the granted requester is still asking.
    assign load_done = (state_q == S_LOAD) && req[gnt_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        reg_d     = reg_q;
        owner_d   = owner_q;
        ack_d     = 4'b0000;
        q_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    gnt_d   = win_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    reg_d     = d_sel;
                    owner_d   = gnt_q;
                    ack_d     = 4'b0001 << gnt_q;
                    q_valid_d = 1'b1;
                    ptr_d     = gnt_q + 2'd1;
                    state_d   = S_ACK;
                end else begin
                    // Request withdrawn: drop the grant, pointer stays put.
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 2'd0;
            reg_q     <= '0;
            owner_q   <= 2'd0;
            ack_q     <= 4'b0000;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            reg_q     <= reg_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            q_valid_q <= q_valid_d;
        end
    end

`ifdef PIPO_ARB_STATS_EN
    logic [7:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q + {7'd0, load_done};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= 8'd0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;
`endif

    assign ack     = ack_q;
    assign q       = reg_q;
    assign q_valid = q_valid_q;
    assign owner   = owner_q;
    assign busy    = (state_q != S_IDLE);

endmodule
